// File: rtl/fetch_controller.sv
// fetch_controller: owns the PC, issues one instruction-memory read per cycle and hands words to the decoder
// Ports: clk/rst (sync, active-high); en fetch enable; imem_en/imem_addr/imem_rdata 1-cycle registered
// instruction memory; redirect_valid/redirect_pc new PC; dec_valid/dec_ready/dec_instr/dec_pc decoder
// handshake; misalign_err sticky flag for a misaligned redirect target.
module fetch_controller #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [ADDR_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [ADDR_W-1:0] dec_instr,
  output logic [ADDR_W-1:0] dec_pc,
  output logic              misalign_err
);
  typedef enum logic [1:0] {RUN, HALT, ERROR} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic [ADDR_W-1:0] out_instr_q, out_instr_d, out_pc_q, out_pc_d;
  logic [ADDR_W-1:0] skid_instr_q, skid_instr_d, skid_pc_q, skid_pc_d;
  logic inflight_q, inflight_d, out_v_q, out_v_d, skid_v_q, skid_v_d, mis_q, mis_d;
  logic fire, issue;
  logic [1:0] occ, occ_next;
  assign fire = out_v_q & dec_ready;
  assign occ = {1'b0, out_v_q} + {1'b0, skid_v_q};
  // fire implies out_v_q, so this never underflows
  assign occ_next = occ + {1'b0, inflight_q} - {1'b0, fire};
  // only issue when the returning word is guaranteed a buffer slot
  assign issue = !rst && state_q == RUN && en && !redirect_valid && occ_next <= 2'd1;
  assign imem_en = issue;
  assign imem_addr = rst ? RESET_PC : pc_q;
  assign dec_valid = out_v_q;
  assign dec_instr = out_instr_q;
  assign dec_pc = out_pc_q;
  assign misalign_err = mis_q;
  always_comb begin
    state_d = state_q;
    mis_d = mis_q;
    pc_d = issue ? pc_q + ADDR_W'(4) : pc_q;
    req_pc_d = pc_q;
    inflight_d = issue;
    out_v_d = out_v_q;
    out_instr_d = out_instr_q;
    out_pc_d = out_pc_q;
    skid_v_d = skid_v_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d = skid_pc_q;
    if (redirect_valid) begin
      mis_d = |redirect_pc[1:0];
      state_d = mis_d ? ERROR : (en ? RUN : HALT);
      pc_d = redirect_pc;
      out_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else begin
      if (state_q == RUN && !en) state_d = HALT;
      if (state_q == HALT && en) state_d = RUN;
      if (fire && skid_v_q) begin
        out_instr_d = skid_instr_q;
        out_pc_d = skid_pc_q;
        skid_v_d = inflight_q;
        skid_instr_d = imem_rdata;
        skid_pc_d = req_pc_q;
      end else if (!out_v_q || fire) begin
        out_v_d = inflight_q;
        out_instr_d = inflight_q ? imem_rdata : out_instr_q;
        out_pc_d = inflight_q ? req_pc_q : out_pc_q;
      end else if (inflight_q) begin
        skid_v_d = 1'b1;
        skid_instr_d = imem_rdata;
        skid_pc_d = req_pc_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q <= RESET_PC;
      req_pc_q <= '0;
      inflight_q <= 1'b0;
      out_v_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q <= '0;
      skid_v_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q <= '0;
      mis_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      req_pc_q <= req_pc_d;
      inflight_q <= inflight_d;
      out_v_q <= out_v_d;
      out_instr_q <= out_instr_d;
      out_pc_q <= out_pc_d;
      skid_v_q <= skid_v_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q <= skid_pc_d;
      mis_q <= mis_d;
    end
  end
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: table-driven and scoreboard checks of fetch_controller
module tb_fetch_controller;
  localparam logic [31:0] K = 32'hA5A5A5A5;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, redirect_valid = 1'b0, dec_ready = 1'b1;
  logic imem_en, dec_valid, misalign_err;
  logic [31:0] imem_addr, dec_instr, dec_pc, redirect_pc = '0, imem_rdata = '0, sb_e;
  int n_cmp = 0, n_err = 0;
  logic [31:0] q[$];
  typedef struct {
    logic en, rdy, exp_en;
    logic [31:0] exp_addr;
    logic exp_dv;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t tbl[11];
  fetch_controller dut (
    .clk(clk), .rst(rst), .en(en), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .misalign_err(misalign_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (imem_en) imem_rdata <= imem_addr ^ K;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && dec_valid && dec_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_extra: got pc %h expected nothing", dec_pc);
      end else begin
        sb_e = q.pop_front();
        chk("sb_pc", dec_pc, sb_e);
        chk("sb_instr", dec_instr, sb_e ^ K);
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    en = 1'b1;
    dec_ready = 1'b1;
    redirect_valid = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask
  task automatic drain();
    en = 1'b0;
    dec_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0 && !dec_valid) break;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
    chk("drain_dv", {31'd0, dec_valid}, 32'd0);
    cyc();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    logic found;
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 32'd4,  1'b0, 32'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 32'd8,  1'b1, 32'd0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 32'd12, 1'b1, 32'd4};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'd16, 1'b1, 32'd8};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'd16, 1'b1, 32'd8};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'd16, 1'b1, 32'd8};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 32'd16, 1'b1, 32'd8};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 32'd20, 1'b1, 32'd12};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 32'd24, 1'b1, 32'd16};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 32'd28, 1'b1, 32'd20};
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_en", {31'd0, imem_en}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_dv", {31'd0, dec_valid}, 32'd0);
    chk("rst_instr", dec_instr, 32'd0);
    chk("rst_pc", dec_pc, 32'd0);
    chk("rst_mis", {31'd0, misalign_err}, 32'd0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 11; i++) begin
      en = tbl[i].en;
      dec_ready = tbl[i].rdy;
      if (tbl[i].exp_en) q.push_back(tbl[i].exp_addr);
      @(negedge clk);
      chk("vec_en", {31'd0, imem_en}, {31'd0, tbl[i].exp_en});
      chk("vec_addr", imem_addr, tbl[i].exp_addr);
      chk("vec_dv", {31'd0, dec_valid}, {31'd0, tbl[i].exp_dv});
      if (tbl[i].exp_dv) chk("vec_pc", dec_pc, tbl[i].exp_pc);
      cyc();
    end
    for (int i = 0; i < 4; i++) begin
      en = 1'b0;
      dec_ready = 1'b1;
      @(negedge clk);
      chk("halt_noissue", {31'd0, imem_en}, 32'd0);
      cyc();
    end
    en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      @(negedge clk);
      if (imem_en) found = 1'b1;
      else cyc();
    end
    chk("resume_found", {31'd0, found}, 32'd1);
    chk("resume_addr", imem_addr, 32'h20);
    if (found) q.push_back(32'h20);
    cyc();
    drain();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) q.push_back(32'(i * 4));
      cyc();
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    chk("rd_noissue", {31'd0, imem_en}, 32'd0);
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("rd_en", {31'd0, imem_en}, 32'd1);
    chk("rd_addr", imem_addr, 32'h100);
    chk("rd_flushed", {31'd0, dec_valid}, 32'd0);
    q.push_back(32'h100);
    cyc();
    @(negedge clk);
    chk("rd_addr2", imem_addr, 32'h104);
    q.push_back(32'h104);
    cyc();
    en = 1'b0;
    @(negedge clk);
    chk("rd_dv", {31'd0, dec_valid}, 32'd1);
    chk("rd_pc", dec_pc, 32'h100);
    drain();
    en = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    @(negedge clk);
    chk("mis_noissue", {31'd0, imem_en}, 32'd0);
    cyc();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mis_flag", {31'd0, misalign_err}, 32'd1);
      chk("mis_noissue2", {31'd0, imem_en}, 32'd0);
      cyc();
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("mis_clear", {31'd0, misalign_err}, 32'd0);
    chk("rec_en", {31'd0, imem_en}, 32'd1);
    chk("rec_addr", imem_addr, 32'h200);
    q.push_back(32'h200);
    cyc();
    drain();
    en = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("wrap_en", {31'd0, imem_en}, 32'd1);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    q.push_back(32'hFFFF_FFFC);
    cyc();
    @(negedge clk);
    chk("wrap_addr1", imem_addr, 32'h0);
    q.push_back(32'h0);
    cyc();
    drain();
    en = 1'b1;
    dec_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 4) begin
        chk("hold_dv", {31'd0, dec_valid}, 32'd1);
        chk("hold_pc", dec_pc, 32'd4);
        chk("hold_instr", dec_instr, 32'd4 ^ K);
      end
      if (i == 5) chk("full_noissue", {31'd0, imem_en}, 32'd0);
      cyc();
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_noissue", {31'd0, imem_en}, 32'd0);
    chk("mrst_addr", imem_addr, 32'd0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("post_dv", {31'd0, dec_valid}, 32'd0);
    chk("post_pc", dec_pc, 32'd0);
    chk("post_instr", dec_instr, 32'd0);
    chk("post_mis", {31'd0, misalign_err}, 32'd0);
    chk("post_en", {31'd0, imem_en}, 32'd1);
    chk("post_addr", imem_addr, 32'd0);
    q.push_back(32'd0);
    cyc();
    @(negedge clk);
    chk("post_addr1", imem_addr, 32'd4);
    q.push_back(32'd4);
    cyc();
    en = 1'b0;
    dec_ready = 1'b1;
    @(negedge clk);
    chk("post_dv2", {31'd0, dec_valid}, 32'd1);
    chk("post_pc2", dec_pc, 32'd0);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
